// File: rtl/spi_cmd_slave.sv
// SPI command slave: receives DATA_W+2-bit frames (2-bit command + payload) and serves reads.
// Define SPI_SLV_PARITY_EN to append and check a trailing odd-parity bit on every receive frame.
module spi_cmd_slave #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

  localparam int unsigned F = DATA_W + 2;
`ifdef SPI_SLV_PARITY_EN
  localparam int unsigned NBITS = F + 1;
`else
  localparam int unsigned NBITS = F;
`endif
  localparam int unsigned CW = $clog2(NBITS + 1);
  localparam int unsigned TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StChkCmd   = 3'd1;
  localparam logic [2:0] StWrite    = 3'd2;
  localparam logic [2:0] StReadAdd  = 3'd3;
  localparam logic [2:0] StReadData = 3'd4;
  localparam logic [2:0] StReadWait = 3'd5;
  localparam logic [2:0] StReadTx   = 3'd6;
  localparam logic [2:0] StDone     = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NBITS-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic              rd_flag_q, rd_flag_d;
  logic [F-1:0]      rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              miso_q, miso_d;
  logic              frame_err_q, frame_err_d;
  logic              par_ok;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    wait_d      = wait_q;
    rd_flag_d   = rd_flag_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    miso_d      = 1'b0;
    frame_err_d = 1'b0;
    par_ok      = 1'b1;

    if (SS_n) begin
      // Deselect always wins; leaving anywhere but IDLE/DONE means the frame was cut short.
      state_d = StIdle;
      if (state_q != StIdle && state_q != StDone) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StChkCmd;
          cnt_d   = CW'(NBITS);
        end
        StChkCmd, StWrite, StReadAdd, StReadData: begin
          shift_d    = shift_q << 1;
          shift_d[0] = MOSI;
          cnt_d      = cnt_q - CW'(1);
          if (state_q == StChkCmd) begin
            if (!MOSI)          state_d = StWrite;
            else if (rd_flag_q) state_d = StReadData;
            else                state_d = StReadAdd;
          end else if (cnt_q == CW'(1)) begin
`ifdef SPI_SLV_PARITY_EN
            par_ok = ^shift_d;
`endif
            if (par_ok) begin
              rx_data_d  = shift_d[NBITS-1 -: F];
              rx_valid_d = 1'b1;
              state_d    = StDone;
              if (state_q == StReadAdd) rd_flag_d = 1'b1;
              if (state_q == StReadData) begin
                state_d = StReadWait;
                wait_d  = '0;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = StDone;
            end
          end
        end
        StReadWait: begin
          if (tx_valid) begin
            tx_d    = tx_data;
            miso_d  = tx_data[DATA_W-1];
            cnt_d   = CW'(DATA_W);
            state_d = StReadTx;
          end else if (TX_TIMEOUT != 0) begin
            if (wait_q == TW'(TX_TIMEOUT - 1)) begin
              frame_err_d = 1'b1;
              rd_flag_d   = 1'b0;
              state_d     = StDone;
            end else begin
              wait_d = wait_q + TW'(1);
            end
          end
        end
        StReadTx: begin
          // cnt_q == 1 is the extra edge after bit 0 that returns MISO to 0.
          tx_d  = tx_q << 1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            rd_flag_d = 1'b0;
            state_d   = StDone;
          end else begin
            miso_d = tx_d[DATA_W-1];
          end
        end
        default: state_d = StDone;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      wait_q      <= '0;
      rd_flag_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      wait_q      <= wait_d;
      rd_flag_q   <= rd_flag_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Scoreboard bench for spi_cmd_slave: a transaction-level model pushes expected events,
// a negedge monitor pops and compares rx_valid / frame_err / MISO bytes.
module tb_spi_cmd_slave;
  localparam int unsigned DW = 8;
  localparam int unsigned F  = DW + 2;
  localparam int unsigned TO = 4;
`ifdef SPI_SLV_PARITY_EN
  localparam int unsigned NB = F + 1;
`else
  localparam int unsigned NB = F;
`endif
  localparam logic [1:0] EvRx = 2'd0, EvErr = 2'd1, EvTx = 2'd2;

  logic          clk = 1'b0;
  logic          rst, ss_n, mosi, miso, rx_valid, tx_valid, frame_err;
  logic [F-1:0]  rx_data;
  logic [DW-1:0] tx_data;

  always #5 clk = ~clk;

  spi_cmd_slave #(.DATA_W(DW), .TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso), .rx_data(rx_data),
    .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid), .frame_err(frame_err)
  );

  typedef struct packed { logic [1:0] kind; logic [F-1:0] val; } ev_t;
  ev_t           exp_q[$];
  ev_t           mon_e;
  int            n_pass = 0, n_total = 0;
  bit            window = 1'b0;
  int            mbits = 0;
  logic [DW-1:0] mshift;
  bit            m_rd_flag = 1'b0;
  logic [F-1:0]  m_last_rx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [1:0] kind, input logic [F-1:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse or completed MISO byte must match the head of the queue.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 || frame_err === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected rx_valid/frame_err", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (rx_valid === 1'b1) begin
          check("rx_valid event kind", 32'(mon_e.kind), 32'(EvRx));
          check("rx_data", 32'(rx_data), 32'(mon_e.val));
        end else begin
          check("frame_err event kind", 32'(mon_e.kind), 32'(EvErr));
        end
      end
    end
    if (window) begin
      mshift = {mshift[DW-2:0], miso};
      mbits++;
      if (mbits == DW) begin
        mbits = 0;
        if (exp_q.size() == 0) check("unexpected MISO byte", 32'(mshift), 32'hFFFF_FFFF);
        else begin
          mon_e = exp_q.pop_front();
          check("MISO event kind", 32'(mon_e.kind), 32'(EvTx));
          check("MISO byte", 32'(mshift), 32'(mon_e.val));
        end
      end
    end else begin
      mbits = 0;
      check("MISO idle zero", 32'(miso), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic junk_tick();
    mosi = 1'($urandom); tx_valid = 1'($urandom); tx_data = DW'($urandom);
    tick();
  endtask

  task automatic wait_tick();
    mosi = 1'($urandom); tx_valid = 1'b0; tx_data = DW'($urandom);
    tick();
  endtask

  // wait_kind (read-data frames only): 0 deliver after wait_d, 1 timeout, 2 deselect, 3 reset in TX.
  task automatic run_frame(input logic [F-1:0] bits, input int abort_at, input bit bad_par,
                           input int wait_kind, input int wait_d, input logic [DW-1:0] txd);
    logic [NB-1:0] fb;
    bit par_bad, rd_data;
`ifdef SPI_SLV_PARITY_EN
    par_bad = bad_par;
    fb = {bits, ~(^bits) ^ bad_par};
`else
    par_bad = 1'b0;
    fb = bits;
`endif
    rd_data = bits[F-1] && m_rd_flag;
    if (abort_at < int'(NB) || par_bad) push(EvErr, '0);
    else push(EvRx, bits);
    ss_n = 1'b0; tx_valid = 1'b0;
    tick();
    for (int i = int'(NB) - 1; i >= 0; i--) begin
      if (int'(NB) - 1 - i == abort_at) begin
        ss_n = 1'b1; mosi = 1'($urandom);
        tick();
        check("rx_data hold after abort", 32'(rx_data), 32'(m_last_rx));
        return;
      end
      mosi = fb[i];
      tick();
    end
    if (par_bad) rd_data = 1'b0;
    else begin
      m_last_rx = bits;
      if (bits[F-1] && !m_rd_flag) m_rd_flag = 1'b1;
    end
    if (rd_data) begin
      case (wait_kind)
        0: begin
          repeat (wait_d) wait_tick();
          tx_valid = 1'b1; tx_data = txd;
          push(EvTx, F'(txd));
          tick();
          window = 1'b1;
          repeat (DW) junk_tick();
          window = 1'b0;
          m_rd_flag = 1'b0;
        end
        1: begin
          push(EvErr, '0);
          repeat (TO) wait_tick();
          m_rd_flag = 1'b0;
        end
        2: begin
          push(EvErr, '0);
          repeat (wait_d) wait_tick();
          ss_n = 1'b1;
          tick();
          check("rx_data hold after wait abort", 32'(rx_data), 32'(m_last_rx));
          return;
        end
        default: begin
          tx_valid = 1'b1; tx_data = txd;
          tick();
          window = 1'b1; tx_valid = 1'b0;
          repeat (3) tick();
          rst = 1'b1;
          tick();
          rst = 1'b0; window = 1'b0; ss_n = 1'b1;
          @(negedge clk); #1;
          check("reset mid-TX MISO", 32'(miso), 32'd0);
          check("reset mid-TX rx_valid", 32'(rx_valid), 32'd0);
          check("reset mid-TX frame_err", 32'(frame_err), 32'd0);
          check("reset mid-TX rx_data", 32'(rx_data), 32'd0);
          m_rd_flag = 1'b0; m_last_rx = '0;
          tick();
          return;
        end
      endcase
    end
    repeat ($urandom_range(0, 2)) junk_tick();
    ss_n = 1'b1; tx_valid = 1'b0;
    tick();
    check("rx_data hold after frame", 32'(rx_data), 32'(m_last_rx));
  endtask

  initial begin
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset MISO", 32'(miso), 32'd0);
    check("reset rx_valid", 32'(rx_valid), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    tick();

    run_frame(10'h0A5, NB, 1'b0, 0, 0, 8'h00);        // plain write
    run_frame(10'h23C, NB, 1'b0, 0, 0, 8'h00);        // read address
    run_frame(10'h300, NB, 1'b0, 0, 0, 8'h96);        // read data, MISO 1001_0110
    run_frame(10'h2C3, NB, 1'b0, 0, 0, 8'h00);        // rd_flag cleared: read address again
    run_frame(10'h155, 5, 1'b0, 0, 0, 8'h00);         // write aborted after 5 bits
    run_frame(10'h300, NB, 1'b0, 1, 0, 8'h00);        // read data, timeout
    run_frame(10'h2AA, NB, 1'b0, 0, 0, 8'h00);        // read address
    run_frame(10'h3FF, NB, 1'b0, 0, 2, 8'h5A);        // read data, late tx_valid
    run_frame(10'h2AA, NB, 1'b0, 0, 0, 8'h00);
    run_frame(10'h300, NB, 1'b0, 3, 0, 8'hC3);        // reset during TX
    run_frame(10'h2F0, NB, 1'b0, 0, 0, 8'h00);        // must be a read address after reset
    run_frame(10'h311, NB, 1'b0, 0, 1, 8'hE7);
`ifdef SPI_SLV_PARITY_EN
    run_frame(10'h1F0, NB, 1'b1, 0, 0, 8'h00);        // bad parity
    run_frame(10'h1F0, NB, 1'b0, 0, 0, 8'h00);        // good parity
`endif

    for (int n = 0; n < 200; n++) begin
      logic [F-1:0] bits;
      int abort_at, wk;
      bits     = F'($urandom);
      abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NB - 1)) : int'(NB);
      wk       = int'($urandom_range(0, 5));
      wk       = (wk >= 3) ? 0 : wk;
      run_frame(bits, abort_at, ($urandom_range(0, 5) == 0), wk,
                int'($urandom_range(0, TO - 1)), DW'($urandom));
    end

    repeat (3) tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
